// File: rtl/mont_pkg.sv
// mont_pkg: shared widths, parameter defaults and FSM state type for the
// Montgomery final-subtraction stage.
// Items: OP_W (modulus/result width), C_W (unreduced product width),
//        DEF_LIMB_W / DEF_N_LIMBS (parameter defaults), state_e.
package mont_pkg;

    localparam int OP_W        = 1024;
    localparam int C_W         = 1028;
    localparam int DEF_LIMB_W  = 64;
    localparam int DEF_N_LIMBS = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/mont_final_sub_if.sv
// mont_final_sub_if: request/result bundle between a Montgomery multiplier
// and the final-subtraction stage.
// Signals: start, in_c, in_m (requester -> stage); result, done, busy,
//          and subtracted when MONT_FINAL_SUB_FLAG_EN is defined (stage -> requester).
interface mont_final_sub_if;
    import mont_pkg::*;

    logic            start;
    logic [C_W-1:0]  in_c;
    logic [OP_W-1:0] in_m;
    logic [OP_W-1:0] result;
    logic            done;
    logic            busy;
`ifdef MONT_FINAL_SUB_FLAG_EN
    logic            subtracted;
`endif

    modport master (
        output start,
        output in_c,
        output in_m,
`ifdef MONT_FINAL_SUB_FLAG_EN
        input  subtracted,
`endif
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  in_c,
        input  in_m,
`ifdef MONT_FINAL_SUB_FLAG_EN
        output subtracted,
`endif
        output result,
        output done,
        output busy
    );

endinterface

// File: rtl/mont_final_sub_limb_sub.sv
// limb_subtractor: combinational LIMB_W-bit a - b - bin.
// Latency: zero (pure combinational). No handshake.
// Ports: a_i, b_i, bin_i in; diff_o, bout_o out (bout_o = 1 when a < b + bin).
module limb_subtractor #(
    parameter int LIMB_W = 64
) (
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic              bin_i,
    output logic [LIMB_W-1:0] diff_o,
    output logic              bout_o
);

    logic [LIMB_W:0] wide;

    // One extra bit on the left: a negative result wraps and sets it,
    // which is exactly the outgoing borrow.
    assign wide   = {1'b0, a_i} - {1'b0, b_i} - {{LIMB_W{1'b0}}, bin_i};
    assign diff_o = wide[LIMB_W-1:0];
    assign bout_o = wide[LIMB_W];

endmodule

// File: rtl/mont_final_sub.sv
// mont_final_sub: reduces a Montgomery product C (< 2M) to C mod M by a
//   limb-serial C - M and a final mux on the borrow.
// Latency: done pulses N_LIMBS+1 edges after the start edge (18 by default), constant.
// Backpressure: none; start is only accepted in IDLE, starts while busy are dropped.
// Ports: clk, resetn (async, active low), bus (mont_final_sub_if.slave).
// Option: MONT_FINAL_SUB_FLAG_EN adds bus.subtracted (1 when M was subtracted).
// N_LIMBS*LIMB_W must be at least C_W (1028).
module mont_final_sub
    import mont_pkg::*;
#(
    parameter int LIMB_W  = DEF_LIMB_W,
    parameter int N_LIMBS = DEF_N_LIMBS
) (
    input  logic            clk,
    input  logic            resetn,
    mont_final_sub_if.slave bus
);

    localparam int W     = LIMB_W * N_LIMBS;
    localparam int CNT_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LIMBS - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [W-1:0]    c_sh_q, c_sh_d;
    logic [W-1:0]    m_sh_q, m_sh_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [OP_W-1:0] c_orig_q, c_orig_d;
    logic [OP_W-1:0] result_q, result_d;
    logic            done_q, done_d;
`ifdef MONT_FINAL_SUB_FLAG_EN
    logic            subtracted_q, subtracted_d;
`endif

    logic [W-1:0]      c_ext, m_ext;
    logic [LIMB_W-1:0] limb_diff;
    logic              limb_bout;

    // Zero-extend both operands to the full limb-aligned width.
    always_comb begin
        c_ext            = '0;
        c_ext[C_W-1:0]   = bus.in_c;
        m_ext            = '0;
        m_ext[OP_W-1:0]  = bus.in_m;
    end

    limb_subtractor #(
        .LIMB_W (LIMB_W)
    ) u_limb_sub (
        .a_i    (c_sh_q[LIMB_W-1:0]),
        .b_i    (m_sh_q[LIMB_W-1:0]),
        .bin_i  (borrow_q),
        .diff_o (limb_diff),
        .bout_o (limb_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        c_sh_d   = c_sh_q;
        m_sh_d   = m_sh_q;
        diff_d   = diff_q;
        c_orig_d = c_orig_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef MONT_FINAL_SUB_FLAG_EN
        subtracted_d = subtracted_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    c_sh_d   = c_ext;
                    m_sh_d   = m_ext;
                    c_orig_d = bus.in_c[OP_W-1:0];
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                // Difference limbs enter at the top, so after N_LIMBS shifts
                // diff holds D = C - M in natural bit order.
                diff_d                 = diff_q >> LIMB_W;
                diff_d[W-1 -: LIMB_W]  = limb_diff;
                c_sh_d   = c_sh_q >> LIMB_W;
                m_sh_d   = m_sh_q >> LIMB_W;
                borrow_d = limb_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                // A final borrow means C < M: keep the untouched copy of C.
                result_d = borrow_q ? c_orig_q : diff_q[OP_W-1:0];
                done_d   = 1'b1;
`ifdef MONT_FINAL_SUB_FLAG_EN
                subtracted_d = ~borrow_q;
`endif
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            c_sh_q   <= '0;
            m_sh_q   <= '0;
            diff_q   <= '0;
            c_orig_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef MONT_FINAL_SUB_FLAG_EN
            subtracted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            c_sh_q   <= c_sh_d;
            m_sh_q   <= m_sh_d;
            diff_q   <= diff_d;
            c_orig_q <= c_orig_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef MONT_FINAL_SUB_FLAG_EN
            subtracted_q <= subtracted_d;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != IDLE);
`ifdef MONT_FINAL_SUB_FLAG_EN
    assign bus.subtracted = subtracted_q;
`endif

endmodule

// File: tb/tb_mont_final_sub.sv
// tb_mont_final_sub: directed plus random operations on mont_final_sub,
// compared against a plain-arithmetic reduction model (C >= M ? C - M : C).
module tb_mont_final_sub;
    import mont_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mont_final_sub_if bus();

    mont_final_sub dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_bits(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got hi=%h lo=%h, need hi=%h lo=%h", tag,
                   obs[OP_W-1 -: 64], obs[63:0], exp[OP_W-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, need %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        logic [OP_W-1:0] v;
        for (int i = 0; i < OP_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Random C with 0 <= C < 2M.
    function automatic logic [C_W-1:0] rand_c(input logic [OP_W-1:0] m);
        logic [C_W-1:0] raw;
        logic [C_W-1:0] two_m;
        raw   = {4'($urandom), rand_op()};
        two_m = C_W'(m) << 1;
        return raw % two_m;
    endfunction

    // Reference: reduce by one conditional subtraction of M.
    function automatic logic [OP_W-1:0] model_result(input logic [C_W-1:0] c, input logic [OP_W-1:0] m);
        logic [C_W-1:0] mm;
        mm = C_W'(m);
        if (c >= mm) return OP_W'(c - mm);
        return c[OP_W-1:0];
    endfunction

    function automatic int model_sub(input logic [C_W-1:0] c, input logic [OP_W-1:0] m);
        return (c >= C_W'(m)) ? 1 : 0;
    endfunction

    // One operation: start at the next edge, then scramble the inputs.
    // With inject set, extra starts are pulsed while busy and the whole
    // 40-cycle window is watched for done pulses; otherwise it returns in
    // the done cycle.
    task automatic run_op(input string tag, input logic [C_W-1:0] c, input logic [OP_W-1:0] m, input bit inject);
        int lat;
        int dones;
        int first;
        int limit;
        logic [OP_W-1:0] exp_r;
        exp_r = model_result(c, m);
        limit = inject ? 40 : 30;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_c  = c;
        bus.in_m  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_c  = {4'($urandom), rand_op()};
        bus.in_m  = rand_op();
        chk_int({tag, "/busy"}, int'(bus.busy), 1);
        lat = 0; dones = 0; first = 0;
        while (lat < limit && !(dones > 0 && !inject)) begin
            @(posedge clk); #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                if (first == 0) first = lat;
            end
            if (inject && (lat == 3 || lat == 10)) begin
                bus.start = 1'b1;
                bus.in_c  = {4'($urandom), rand_op()};
                bus.in_m  = rand_op();
            end
        end
        chk_int({tag, "/done_count"}, dones, 1);
        chk_int({tag, "/latency"}, first, 18);
        chk_bits({tag, "/result"}, bus.result, exp_r);
`ifdef MONT_FINAL_SUB_FLAG_EN
        chk_int({tag, "/subtracted"}, int'(bus.subtracted), model_sub(c, m));
`endif
    endtask

    logic [C_W-1:0]  c;
    logic [OP_W-1:0] m;
    logic [OP_W-1:0] held;
    int              dones_after;

    initial begin
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.in_c  = '0;
        bus.in_m  = '0;
        #12;
        chk_bits("reset/result", bus.result, '0);
        chk_int("reset/done", int'(bus.done), 0);
        chk_int("reset/busy", int'(bus.busy), 0);
`ifdef MONT_FINAL_SUB_FLAG_EN
        chk_int("reset/subtracted", int'(bus.subtracted), 0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // C equal to M reduces to zero.
        m = rand_op();
        m[7:0] = 8'hF1;
        run_op("c_eq_m", C_W'(m), m, 1'b0);

        // C just below M is passed through unchanged.
        m = '0;
        m[OP_W-1] = 1'b1;
        m = m + OP_W'(5);
        run_op("c_lt_m", C_W'(m) - C_W'(1), m, 1'b0);

        // done is a single pulse; result holds afterwards.
        held = m - OP_W'(1);
        @(posedge clk); #1;
        chk_int("hold/done_low", int'(bus.done), 0);
        chk_bits("hold/result", bus.result, held);
        repeat (3) @(posedge clk);
        #1;
        chk_bits("hold/result_later", bus.result, held);

        // C = 2M - 1 with C wider than 1024 bits.
        m = '1;
        m = m - OP_W'(2);
        c = (C_W'(m) << 1) - C_W'(1);
        run_op("c_2m_minus1", c, m, 1'b0);

        // Borrow ripples through every limb.
        c = '0;
        c[OP_W] = 1'b1;
        m = '1;
        run_op("full_borrow", c, m, 1'b0);

        // Starts during a busy operation are dropped.
        m = rand_op();
        m[OP_W-1] = 1'b1;
        run_op("ignored_starts", rand_c(m), m, 1'b1);

        // Back-to-back: a start issued in the done cycle is accepted.
        m = rand_op();
        m[OP_W-1] = 1'b1;
        run_op("b2b_first", rand_c(m), m, 1'b0);
        chk_int("b2b/in_done_cycle", int'(bus.done), 1);
        m = rand_op();
        m[OP_W-1] = 1'b1;
        run_op("b2b_second", rand_c(m), m, 1'b0);

        // Random operands within the precondition.
        for (int k = 0; k < 6; k++) begin
            m = rand_op();
            m[OP_W-1 -: 2] = 2'($urandom_range(1, 3));
            run_op($sformatf("random%0d", k), rand_c(m), m, 1'b0);
        end

        // Precondition violated (C >= 2M): still C - M truncated.
        m = '0;
        m[63:0] = {$urandom, $urandom};
        c = {4'hF, rand_op()};
        run_op("c_ge_2m", c, m, 1'b0);

        // Reset in the middle of an operation.
        m = rand_op();
        m[OP_W-1] = 1'b1;
        c = rand_c(m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_c  = c;
        bus.in_m  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk_bits("midreset/result", bus.result, '0);
        chk_int("midreset/done", int'(bus.done), 0);
        chk_int("midreset/busy", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        dones_after = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones_after++;
        end
        chk_int("midreset/no_done", dones_after, 0);
        run_op("after_reset", c, m, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
